// File: rtl/tt_dfd_ccg_ctrl.sv
// tt_dfd_ccg_ctrl: clock-enable controller for a bank of DFD clock-gating cells.
// Latency: req sampled -> PEND next edge -> clk_en one edge later -> ack WAKE_LAT edges after that.
// Backpressure: wake grants are staggered STAGGER_CYC apart (round-robin); requesters simply wait in PEND.
//
// Ports:
//   clk, rst         free-running clock, asynchronous active-high reset
//   req[N]           per-domain clock request
//   busy[N]          per-domain activity; keeps the clock on after req drops
//   cfg_force_en     forces every clk_en high (registered), FSMs unaffected
//   cfg_idle_thresh  idle cycles spent in DRAIN before the clock turns off
//   clk_en[N]        registered enable to the gating cells (all-ones in reset)
//   ack[N]           registered; domain clock is on and settled
//   all_off          combinational; every domain FSM is in OFF
module tt_dfd_ccg_ctrl #(
  parameter int NUM_DOM     = 4,
  parameter int STAGGER_CYC = 4,
  parameter int WAKE_LAT    = 2,
  parameter int IDLE_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_DOM-1:0] req,
  input  logic [NUM_DOM-1:0] busy,
  input  logic               cfg_force_en,
  input  logic [IDLE_W-1:0]  cfg_idle_thresh,
  output logic [NUM_DOM-1:0] clk_en,
  output logic [NUM_DOM-1:0] ack,
  output logic               all_off
);

  localparam int SW = (WAKE_LAT > 0) ? $clog2(WAKE_LAT + 1) : 1;
  localparam int GW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
  localparam int PW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [SW-1:0] SETTLE_INIT = SW'(WAKE_LAT);
  localparam logic [GW-1:0] STAG_INIT   = GW'(STAGGER_CYC - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_PEND  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             state_q  [NUM_DOM];
  state_t             state_d  [NUM_DOM];
  logic [SW-1:0]      settle_q [NUM_DOM];
  logic [SW-1:0]      settle_d [NUM_DOM];
  logic [IDLE_W-1:0]  idle_q   [NUM_DOM];
  logic [IDLE_W-1:0]  idle_d   [NUM_DOM];
  logic [GW-1:0]      stag_q, stag_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NUM_DOM-1:0] clk_en_q, clk_en_d;
  logic [NUM_DOM-1:0] ack_q, ack_d;
  logic [NUM_DOM-1:0] pend;
  logic [NUM_DOM-1:0] grant;
  logic               fire;
  logic               hi_any;
  int                 hi_sel, lo_sel, sel;

  // A PEND domain whose req has already dropped is withdrawing this cycle and
  // must not be granted.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      pend[i] = (state_q[i] == ST_PEND) && req[i];
    end
  end

  // Round-robin pick: ptr_q holds the first index to search (one past the last
  // grantee). Prefer the lowest pending index >= ptr_q, else wrap to the lowest.
  always_comb begin
    hi_any = 1'b0;
    hi_sel = 0;
    lo_sel = 0;
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (pend[i]) begin
        lo_sel = i;
        if (i >= int'(ptr_q)) begin
          hi_sel = i;
          hi_any = 1'b1;
        end
      end
    end
    sel  = hi_any ? hi_sel : lo_sel;
    fire = (stag_q == '0) && (|pend);
    grant = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      grant[i] = fire && (sel == i);
    end
    ptr_d  = ptr_q;
    stag_d = stag_q;
    if (fire) begin
      ptr_d  = PW'((sel + 1) % NUM_DOM);
      stag_d = STAG_INIT;
    end else if (stag_q != '0) begin
      stag_d = stag_q - GW'(1);
    end
  end

  always_comb begin
    clk_en_d = '0;
    ack_d    = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      state_d[i]  = state_q[i];
      settle_d[i] = settle_q[i];
      idle_d[i]   = idle_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (req[i]) state_d[i] = ST_PEND;
        end
        ST_PEND: begin
          if (!req[i]) begin
            state_d[i] = ST_OFF;
          end else if (grant[i]) begin
            state_d[i]  = ST_ON;
            settle_d[i] = SETTLE_INIT;
          end
        end
        ST_ON: begin
          if (!req[i] && !busy[i]) begin
            state_d[i] = ST_DRAIN;
            idle_d[i]  = cfg_idle_thresh;
          end else if (settle_q[i] != '0) begin
            settle_d[i] = settle_q[i] - SW'(1);
          end
        end
        ST_DRAIN: begin
          // Clock never stopped during DRAIN, so reentry needs no resettle and
          // takes priority over the idle count expiring.
          if (req[i] || busy[i]) begin
            state_d[i]  = ST_ON;
            settle_d[i] = '0;
          end else if (idle_q[i] == '0) begin
            state_d[i] = ST_OFF;
          end else begin
            idle_d[i] = idle_q[i] - IDLE_W'(1);
          end
        end
        default: state_d[i] = ST_OFF;
      endcase
      clk_en_d[i] = (state_d[i] == ST_ON) || (state_d[i] == ST_DRAIN) || cfg_force_en;
      // ack answers an active request; a busy-only hold keeps the clock but not ack.
      ack_d[i] = (state_d[i] == ST_ON) && (settle_d[i] == '0) && req[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        state_q[i]  <= ST_OFF;
        settle_q[i] <= '0;
        idle_q[i]   <= '0;
      end
      stag_q   <= '0;
      ptr_q    <= '0;
      clk_en_q <= '1; // clocks run in reset so downstream resets propagate
      ack_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_DOM; i++) begin
        state_q[i]  <= state_d[i];
        settle_q[i] <= settle_d[i];
        idle_q[i]   <= idle_d[i];
      end
      stag_q   <= stag_d;
      ptr_q    <= ptr_d;
      clk_en_q <= clk_en_d;
      ack_q    <= ack_d;
    end
  end

  always_comb begin
    all_off = 1'b1;
    for (int i = 0; i < NUM_DOM; i++) begin
      if (state_q[i] != ST_OFF) all_off = 1'b0;
    end
  end

  assign clk_en = clk_en_q;
  assign ack    = ack_q;

endmodule
